branch_resolver: RTL and testbench

Execute-stage branch resolution and prediction unit for the pipelined RISC-V core. It decodes the comparator's 2-bit `branch_type` result against the branch `funct3` to determine the actual outcome. It also supplies the comparator's signed/unsigned select, checks the outcome against the prediction carried down the pipe, and issues a registered PC redirect plus a two-cycle flush on a mispredict. A bimodal table of 2-bit counters, read combinationally by fetch, provides the predictions and is updated on every resolved branch.

---
 rtl/branch_resolver_if.sv | 33 +++
 rtl/branch_resolver.sv | 117 +++++++++++
 tb/tb_branch_resolver.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/branch_resolver_if.sv
// Execute/fetch-side signal bundle for branch_resolver.
// master: pipeline side driving execute/fetch inputs; slave: the resolver.
interface branch_resolver_if;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_branch_type;
  logic        branch_unsigned;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;

  modport master (
    output if_pc, ex_valid, ex_is_branch, ex_funct3, ex_branch_type,
           ex_pc, ex_target, ex_pred_taken,
    input  pred_taken, branch_unsigned, redirect_valid, redirect_pc,
           flush, perf_branches, perf_mispredicts
  );

  modport slave (
    input  if_pc, ex_valid, ex_is_branch, ex_funct3, ex_branch_type,
           ex_pc, ex_target, ex_pred_taken,
    output pred_taken, branch_unsigned, redirect_valid, redirect_pc,
           flush, perf_branches, perf_mispredicts
  );
endinterface

// File: rtl/branch_resolver.sv
// Execute-stage branch resolution, bimodal predictor, and mispredict redirect/flush.
// FSM state is exported on dbg_state_o (0 IDLE, 1 FLUSH1, 2 FLUSH2).
module branch_resolver #(
  parameter int BHT_ENTRIES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_resolver_if.slave     bus,
  output logic [1:0]           dbg_state_o
);
  localparam int IDX = $clog2(BHT_ENTRIES);

  // Execute handshake: there is no ready; an instruction is consumed in the
  // cycle ex_valid is high, and is dropped unless the resolver is IDLE.
  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH1 = 2'd1, FLUSH2 = 2'd2} state_e;

  state_e      state_q, state_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic        flush_q, flush_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] perf_br_q, perf_br_d;
  logic [31:0] perf_mp_q, perf_mp_d;
  logic [1:0]  bht_q [BHT_ENTRIES];

  logic           funct3_legal;
  logic           is_eq, is_lt;
  logic           actual_taken;
  logic           resolve;
  logic           mispredict;
  logic [IDX-1:0] upd_idx;
  logic [IDX-1:0] rd_idx;
  logic [1:0]     bht_cur, bht_nxt;

  assign upd_idx = bus.ex_pc[IDX+1:2];
  assign rd_idx  = bus.if_pc[IDX+1:2];
  assign bht_cur = bht_q[upd_idx];

  always_comb begin
    is_eq        = (bus.ex_branch_type == 2'b10);
    is_lt        = (bus.ex_branch_type == 2'b01);
    funct3_legal = 1'b1;
    actual_taken = 1'b0;
    case (bus.ex_funct3)
      3'b000:          actual_taken = is_eq;
      3'b001:          actual_taken = !is_eq;
      3'b100, 3'b110:  actual_taken = is_lt;
      3'b101, 3'b111:  actual_taken = !is_lt;
      default:         funct3_legal = 1'b0;
    endcase
    resolve    = bus.ex_valid && bus.ex_is_branch && (state_q == IDLE) &&
                 funct3_legal && (bus.ex_branch_type != 2'b11);
    mispredict = resolve && (actual_taken != bus.ex_pred_taken);

    if (actual_taken) bht_nxt = (bht_cur == 2'b11) ? 2'b11 : bht_cur + 2'b01;
    else              bht_nxt = (bht_cur == 2'b00) ? 2'b00 : bht_cur - 2'b01;
  end

  always_comb begin
    state_d          = state_q;
    redirect_valid_d = 1'b0;
    flush_d          = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    perf_br_d        = perf_br_q;
    perf_mp_d        = perf_mp_q;
    if (resolve) perf_br_d = perf_br_q + 32'd1;
    case (state_q)
      IDLE: begin
        if (mispredict) begin
          state_d          = FLUSH1;
          redirect_valid_d = 1'b1;
          flush_d          = 1'b1;
          redirect_pc_d    = actual_taken ? bus.ex_target : bus.ex_pc + 32'd4;
          perf_mp_d        = perf_mp_q + 32'd1;
        end
      end
      FLUSH1: begin
        state_d = FLUSH2;
        flush_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      redirect_pc_q    <= 32'd0;
      perf_br_q        <= 32'd0;
      perf_mp_q        <= 32'd0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      flush_q          <= flush_d;
      redirect_pc_q    <= redirect_pc_d;
      perf_br_q        <= perf_br_d;
      perf_mp_q        <= perf_mp_d;
      if (resolve) bht_q[upd_idx] <= bht_nxt;
    end
  end

  // Read returns the pre-update counter when fetch and execute hit the same entry.
  assign bus.pred_taken       = bht_q[rd_idx][1];
  assign bus.branch_unsigned  = bus.ex_funct3[1];
  assign bus.redirect_valid   = redirect_valid_q;
  assign bus.redirect_pc      = redirect_pc_q;
  assign bus.flush            = flush_q;
  assign bus.perf_branches    = perf_br_q;
  assign bus.perf_mispredicts = perf_mp_q;
  assign dbg_state_o          = state_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.if_pc[31:IDX+2], bus.if_pc[1:0],
                            bus.ex_pc[1:0]};
endmodule

// File: tb/tb_branch_resolver.sv
// Randomized + directed bench for branch_resolver against a behavioural model.
module tb_branch_resolver;
  localparam int ENTRIES = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_fail   = 0;

  branch_resolver_if bus ();

  branch_resolver #(.BHT_ENTRIES(ENTRIES)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model: predictor counters as integers, flush as cycles remaining.
  int          m_bht [ENTRIES];
  int          m_flush_left;
  logic        m_rv;
  logic        m_flush;
  logic [31:0] m_rpc;
  logic [31:0] m_nbr;
  logic [31:0] m_nmp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic bit branch_taken(input logic [2:0] f3, input logic [1:0] ty);
    bit eq = (ty == 2'd2);
    bit lt = (ty == 2'd1);
    case (f3)
      3'd0:       return eq;
      3'd1:       return !eq;
      3'd4, 3'd6: return lt;
      default:    return !lt;
    endcase
  endfunction

  task automatic model_edge();
    bit legal, res, act;
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) m_bht[i] = 1;
      m_flush_left = 0; m_rv = 0; m_flush = 0; m_rpc = 0; m_nbr = 0; m_nmp = 0;
      return;
    end
    legal = !(bus.ex_funct3 inside {3'd2, 3'd3});
    res = bus.ex_valid && bus.ex_is_branch && m_flush_left == 0 && legal &&
          bus.ex_branch_type != 2'd3;
    m_rv = 0;
    if (m_flush_left > 0) m_flush_left--;
    if (res) begin
      act = branch_taken(bus.ex_funct3, bus.ex_branch_type);
      m_nbr++;
      if (act) m_bht[idx_of(bus.ex_pc)] = (m_bht[idx_of(bus.ex_pc)] < 3) ? m_bht[idx_of(bus.ex_pc)] + 1 : 3;
      else     m_bht[idx_of(bus.ex_pc)] = (m_bht[idx_of(bus.ex_pc)] > 0) ? m_bht[idx_of(bus.ex_pc)] - 1 : 0;
      if (act != bus.ex_pred_taken) begin
        m_nmp++;
        m_rv = 1;
        m_flush_left = 2;
        m_rpc = act ? bus.ex_target : bus.ex_pc + 32'd4;
      end
    end
    m_flush = (m_flush_left > 0);
  endtask

  // One clock: combinational checks before the edge, registered checks after.
  task automatic cycle();
    #1;
    check("pred_taken_pre", {31'd0, bus.pred_taken}, {31'd0, m_bht[idx_of(bus.if_pc)] >= 2});
    check("branch_unsigned", {31'd0, bus.branch_unsigned}, {31'd0, bus.ex_funct3[1]});
    @(posedge clk);
    model_edge();
    #1;
    check("redirect_valid", {31'd0, bus.redirect_valid}, {31'd0, m_rv});
    check("flush", {31'd0, bus.flush}, {31'd0, m_flush});
    check("redirect_pc", bus.redirect_pc, m_rpc);
    check("perf_branches", bus.perf_branches, m_nbr);
    check("perf_mispredicts", bus.perf_mispredicts, m_nmp);
    check("pred_taken_post", {31'd0, bus.pred_taken}, {31'd0, m_bht[idx_of(bus.if_pc)] >= 2});
  endtask

  task automatic drv(input bit v, input bit br, input logic [2:0] f3, input logic [1:0] ty,
                     input logic [31:0] pc, input logic [31:0] tgt, input bit pt,
                     input logic [31:0] ifpc);
    bus.ex_valid = v; bus.ex_is_branch = br; bus.ex_funct3 = f3;
    bus.ex_branch_type = ty; bus.ex_pc = pc; bus.ex_target = tgt;
    bus.ex_pred_taken = pt; bus.if_pc = ifpc;
  endtask

  task automatic idle(input int n, input logic [31:0] ifpc);
    for (int i = 0; i < n; i++) begin
      drv(0, 0, 3'd0, 2'd0, 32'h0, 32'h0, 0, ifpc);
      cycle();
    end
  endtask

  logic [31:0] pc_tab [8];

  initial begin
    pc_tab = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h100, 32'h140, 32'hFFFFFFFC, 32'h1000_0048};
    drv(0, 0, 3'd0, 2'd0, 32'h0, 32'h0, 0, 32'h0);
    rst = 1;
    cycle(); cycle();
    rst = 0;
    idle(5, 32'h0);
    idle(1, 32'h100);
    check("reset_perf_br", bus.perf_branches, 32'd0);

    // BEQ taken, predicted not taken: redirect to target, two flush cycles.
    drv(1, 1, 3'd0, 2'b10, 32'h40, 32'h80, 0, 32'h40);
    cycle();
    check("beq_rpc", bus.redirect_pc, 32'h80);
    check("beq_rv", {31'd0, bus.redirect_valid}, 32'd1);
    idle(1, 32'h40);
    check("beq_flush2", {31'd0, bus.flush}, 32'd1);
    check("beq_rv2", {31'd0, bus.redirect_valid}, 32'd0);
    idle(1, 32'h40);
    check("beq_bht16_taken", {31'd0, bus.pred_taken}, 32'd1);

    // BGEU not taken, correctly predicted.
    drv(1, 1, 3'd7, 2'b01, 32'h44, 32'h90, 0, 32'h44);
    cycle();
    check("bgeu_no_flush", {31'd0, bus.flush}, 32'd0);

    // Four taken BNEs at 0x48 saturate the counter; fetch reads the same entry.
    for (int i = 0; i < 4; i++) begin
      drv(1, 1, 3'd1, 2'b00, 32'h48, 32'hA0, 1, 32'h48);
      cycle();
    end
    check("bne_sat_pred", {31'd0, bus.pred_taken}, 32'd1);

    // Mispredict then branches during FLUSH1/FLUSH2 are ignored; illegal funct3 too.
    drv(1, 1, 3'd4, 2'b01, 32'h4C, 32'hC0, 0, 32'h4C);
    cycle();
    drv(1, 1, 3'd0, 2'b10, 32'h4C, 32'hC0, 0, 32'h4C);
    cycle(); cycle();
    drv(1, 1, 3'd2, 2'b10, 32'h4C, 32'hC0, 0, 32'h4C);
    cycle();
    check("ignored_perf_mp", bus.perf_mispredicts, 32'd2);

    // Fall-through wrap at top of address space, then reset during FLUSH1.
    drv(1, 1, 3'd0, 2'b00, 32'hFFFFFFFC, 32'h200, 1, 32'hFFFFFFFC);
    cycle();
    check("wrap_rpc", bus.redirect_pc, 32'h0);
    rst = 1;
    idle(1, 32'h48);
    rst = 0;
    check("rst_flush", {31'd0, bus.flush}, 32'd0);
    check("rst_pred48", {31'd0, bus.pred_taken}, 32'd0);
    for (int i = 0; i < ENTRIES; i++) begin
      bus.if_pc = 32'(i) << 2;
      #1 check("rst_bht", {31'd0, bus.pred_taken}, 32'd0);
    end

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc;
      pc = pc_tab[$urandom_range(0, 7)];
      rst = ($urandom_range(0, 99) == 0);
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
          3'($urandom_range(0, 7)),
          ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
          pc, $urandom, $urandom_range(0, 1),
          ($urandom_range(0, 1) == 0) ? pc : pc_tab[$urandom_range(0, 7)]);
      cycle();
    end
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
